lsu_mem_master: RTL
===================

Name: lsu_mem_master

Overview:
Initiator side of the byte-addressed data memory port: sits between the CPU execute/memory stage and the memory block. Accepts one load/store request per valid/ready handshake and drives the memory's address/data/read_write/access_size/unsigned_access signals. Returns load data or store completion through a held response handshake. Misaligned accesses are optionally split into sequential byte accesses.

Parameters:
ALLOW_MISALIGNED, 1, 1 = split misaligned half/word into byte accesses; 0 = return fault with no memory access.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept; high only in IDLE
req_store  in  1  1 = store, 0 = load
req_funct3  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only)
req_address  in  32  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  response held until resp_ready
resp_ready  in  1  consumer accepts response
resp_data  out  32  extended load data; 0 for stores and faults
resp_fault  out  1  misaligned (ALLOW_MISALIGNED=0) or illegal funct3
mem_address  out  32  to memory address
mem_wdata  out  32  to memory data_in
mem_rdata  in  32  from memory data_out (combinational read)
mem_read_write  out  1  1 = read, 0 = write (memory writes at posedge when 0)
mem_access_size  out  2  00 byte, 01 half, 10 word
mem_unsigned_access  out  1  zero-extend on read

Behaviour:
- Reset (async, immediate): state IDLE, req_ready 1, resp_valid 0, resp_data 0, resp_fault 0, mem_read_write 1, mem_address 0, mem_wdata 0, mem_access_size 10, mem_unsigned_access 0. Deasserting write asynchronously guarantees a store in progress performs no further writes.
- mem_read_write is 0 only in ACCESS/SPLIT cycles of a store; 1 in every other cycle.
- States: IDLE, ACCESS, SPLIT, RESP.
- IDLE: on req_valid&&req_ready, register request. Illegal funct3 (011,110,111; or 1xx with store) -> RESP, fault. Misaligned (H with addr[0]=1; W with addr[1:0]!=0): ALLOW_MISALIGNED=0 -> RESP, fault; else SPLIT, byte counter 0, byte count N=2 (H) or 4 (W). Otherwise -> ACCESS.
- ACCESS (one cycle): drive address, access_size from funct3[1:0], unsigned from funct3[2], wdata. Load: capture mem_rdata into resp_data at the closing edge. -> RESP.
- SPLIT (N cycles): mem_address = base + k (32-bit wrap), size byte, unsigned 1. Store: mem_wdata[7:0] = wdata byte k. Load: capture mem_rdata[7:0] into assembly byte k. At k=N-1, extend assembled value per funct3 (sign from byte N-1 unless unsigned) -> RESP.
- RESP: resp_valid 1; resp_data/resp_fault stable until resp_ready; on handshake -> IDLE (req_ready rises next cycle; no same-cycle re-accept).
- Latency accept edge to resp_valid: aligned 2 cycles; split N+1 cycles; fault 1 cycle.
- Fault responses never leave mem_read_write 0 and never issue an access.
- Request inputs are ignored outside IDLE; response is held indefinitely under backpressure.

Decomposition:
- Shared package (mem_defs): ACCESS_SIZE_BYTE/HALF/WORD constants (same encodings as the memory), funct3 constants, state encoding.
- One sub-module: lsu_load_extend (combinational; 32-bit raw value, funct3 -> sign/zero-extended result), reused by ACCESS and SPLIT completion.

Test Plan:
- Aligned LW at 0x01000000, memory word 0x8BADF00D -> resp_data 0x8BADF00D, fault 0, resp_valid 2 cycles after accept, one ACCESS cycle with size 10.
- LB at 0x01000003, byte 0x80 -> 0xFFFFFF80; LBU same address -> 0x00000080; LHU at 0x01000002, bytes 0x80,0xFF -> 0x0000FF80.
- Misaligned SW 0x11223344 at 0x01000001 -> four byte write cycles at 0x01000001..4 with data 44,33,22,11; then misaligned LW same address -> 0x11223344, resp_valid 5 cycles after accept.
- ALLOW_MISALIGNED=0, LH at 0x01000001 -> resp_fault 1, resp_data 0, mem_read_write 1 every cycle; funct3 011 load -> fault as well.
- Reset asserted mid-cycle during SPLIT store k=1 -> mem_read_write 1 immediately, only the byte at k=0 changed in memory, resp_valid 0, req_ready 1 after release.
- resp_ready held low 3 cycles after LW -> resp_valid/resp_data stable, req_ready 0, new req_valid ignored until handshake.

Source files
------------

// File: rtl/lsu_mem_master_pkg.sv
// Shared definitions for the LSU memory master: access-size and funct3 encodings,
// controller states, and request classification helpers.
package lsu_mem_master_pkg;

  localparam logic [1:0] ACCESS_SIZE_BYTE = 2'b00;
  localparam logic [1:0] ACCESS_SIZE_HALF = 2'b01;
  localparam logic [1:0] ACCESS_SIZE_WORD = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_SPLIT,
    ST_RESP
  } lsu_state_t;

  // Unsigned variants exist only for loads; 011/110/111 are never legal.
  function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (store && f3[2]);
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return |addr_lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Request/response handshake between the execute/memory stage (master)
// and the LSU memory master (slave).
interface lsu_mem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_fault;

  modport master (
    output req_valid, req_store, req_funct3, req_address, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_fault
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_address, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_data, resp_fault
  );
endinterface

// File: rtl/lsu_mem_master_load_extend.sv
// Sign/zero extension of raw load data according to the RV32 load funct3.
module lsu_load_extend
  import lsu_mem_master_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  always_comb begin
    result = raw;
    case (funct3)
      F3_B:    result = {{24{raw[7]}}, raw[7:0]};
      F3_H:    result = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   result = {24'h0, raw[7:0]};
      F3_HU:   result = {16'h0, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Initiator side of the byte-addressed data memory port: one load/store per
// handshake, optional byte-splitting of misaligned accesses, held response.
module lsu_mem_master
  import lsu_mem_master_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  lsu_mem_master_if.slave    bus,
  output logic [31:0]        mem_address,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata,
  output logic               mem_read_write,
  output logic [1:0]         mem_access_size,
  output logic               mem_unsigned_access
);

  lsu_state_t  state, state_next;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q, asm_q, asm_next, resp_data_q;
  logic        resp_fault_q;
  logic [1:0]  k_q, last_k_q;
  logic [31:0] ext_raw, ext_result;
  logic        req_illegal, req_misaligned, req_fault;

  assign req_illegal    = f3_illegal(bus.req_store, bus.req_funct3);
  assign req_misaligned = f3_misaligned(bus.req_funct3, bus.req_address[1:0]);
  assign req_fault      = req_illegal || (req_misaligned && !ALLOW_MISALIGNED);

  always_comb begin
    asm_next = asm_q;
    asm_next[{k_q, 3'b000} +: 8] = mem_rdata[7:0];
  end

  // Split loads extend the assembled value including the byte arriving this cycle.
  assign ext_raw = (state == ST_SPLIT) ? asm_next : mem_rdata;

  lsu_load_extend u_extend (
    .raw    (ext_raw),
    .funct3 (funct3_q),
    .result (ext_result)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Memory outputs are decoded from state so an async reset drops writes at once.
  always_comb begin
    state_next          = state;
    mem_address         = '0;
    mem_wdata           = '0;
    mem_read_write      = 1'b1;
    mem_access_size     = ACCESS_SIZE_WORD;
    mem_unsigned_access = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (req_fault)           state_next = ST_RESP;
          else if (req_misaligned) state_next = ST_SPLIT;
          else                     state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_address         = addr_q;
        mem_wdata           = wdata_q;
        mem_read_write      = !store_q;
        mem_access_size     = funct3_q[1:0];
        mem_unsigned_access = funct3_q[2];
        state_next          = ST_RESP;
      end
      ST_SPLIT: begin
        mem_address         = addr_q + {30'b0, k_q};
        mem_wdata           = {24'h0, wdata_q[{k_q, 3'b000} +: 8]};
        mem_read_write      = !store_q;
        mem_access_size     = ACCESS_SIZE_BYTE;
        mem_unsigned_access = 1'b1;
        if (k_q == last_k_q) state_next = ST_RESP;
      end
      ST_RESP: begin
        if (bus.resp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      store_q      <= 1'b0;
      funct3_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      asm_q        <= '0;
      k_q          <= '0;
      last_k_q     <= '0;
      resp_data_q  <= '0;
      resp_fault_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            store_q      <= bus.req_store;
            funct3_q     <= bus.req_funct3;
            addr_q       <= bus.req_address;
            wdata_q      <= bus.req_wdata;
            asm_q        <= '0;
            k_q          <= '0;
            last_k_q     <= (bus.req_funct3[1:0] == 2'b01) ? 2'd1 : 2'd3;
            resp_data_q  <= '0;
            resp_fault_q <= req_fault;
          end
        end
        ST_ACCESS: begin
          if (!store_q) resp_data_q <= ext_result;
        end
        ST_SPLIT: begin
          k_q   <= k_q + 2'd1;
          asm_q <= asm_next;
          if ((k_q == last_k_q) && !store_q) resp_data_q <= ext_result;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.resp_valid = (state == ST_RESP);
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_fault = resp_fault_q;

endmodule
